// File: rtl/btn_pulse_gen_if.sv
// Button conditioning bus: raw inputs in, debounced levels and press pulses out.
interface btn_pulse_gen_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic             any_pulse;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  any_pulse
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output any_pulse
    );
endinterface

// File: rtl/btn_pulse_gen.sv
// Per-input 2-FF synchronizer, debounce counter and rising-edge one-shot.
// Optional auto-repeat of held presses is enabled by defining BTN_AUTOREPEAT_EN.
module btn_pulse_gen #(
    parameter int N_BTN         = 4,
    parameter int DB_CYCLES     = 1000000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 20000000
) (
    input  logic            clk,
    input  logic            rst,
    btn_pulse_gen_if.slave  io
);
    localparam int             CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

    logic [N_BTN-1:0] sync1_q;
    logic [N_BTN-1:0] sync2_q;
    logic [N_BTN-1:0] level_w;
    logic [N_BTN-1:0] pulse_w;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= io.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;
            logic          level_q;
            logic          level_d;
            logic          pulse_q;
            logic          pulse_d;
            logic          accept;
            logic          rep_fire;

            // The counter only ever reaches DB_CYCLES-1: the accepting edge clears it.
            always_comb begin
                accept  = (sync2_q[gi] != level_q) && (cnt_q == DB_LAST);
                cnt_d   = '0;
                level_d = level_q;
                if (sync2_q[gi] != level_q) begin
                    if (accept) begin
                        level_d = sync2_q[gi];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                pulse_d = (accept & sync2_q[gi]) | rep_fire;
            end

`ifdef BTN_AUTOREPEAT_EN
            localparam int            HMAX       = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
            localparam int            HW         = $clog2(HMAX + 1);
            localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
            localparam logic [HW-1:0] REP_LAST   = HW'(REPEAT_CYCLES - 1);

            logic [HW-1:0] hold_q;
            logic [HW-1:0] hold_d;
            logic          rep_q;
            logic          rep_d;

            // Count only while the level is high now and stays high this edge.
            always_comb begin
                hold_d   = '0;
                rep_d    = 1'b0;
                rep_fire = 1'b0;
                if (level_q && level_d) begin
                    if (hold_q == (rep_q ? REP_LAST : HOLD_LAST)) begin
                        rep_fire = 1'b1;
                        rep_d    = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                        rep_d  = rep_q;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    hold_q <= '0;
                    rep_q  <= 1'b0;
                end else begin
                    hold_q <= hold_d;
                    rep_q  <= rep_d;
                end
            end
`else
            assign rep_fire = 1'b0;
`endif

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    cnt_q   <= '0;
                    level_q <= 1'b0;
                    pulse_q <= 1'b0;
                end else begin
                    cnt_q   <= cnt_d;
                    level_q <= level_d;
                    pulse_q <= pulse_d;
                end
            end

            assign level_w[gi] = level_q;
            assign pulse_w[gi] = pulse_q;
        end
    endgenerate

    assign io.btn_level = level_w;
    assign io.btn_pulse = pulse_w;
    assign io.any_pulse = |pulse_w;
endmodule

// File: doc/btn_pulse_gen.md
Name: btn_pulse_gen

Overview:
- Input conditioning stage that sits directly upstream of the game FSM.
- Takes raw board push-buttons and switches, and produces:
  - clean debounced levels, used for st_sw-style switch inputs;
  - single-cycle press pulses, used for the FSM's active/reset strobe inputs.
- Each input gets a 2-FF synchronizer, a per-input debounce counter and a rising-edge one-shot.

Parameters:
- N_BTN, 4, number of independent inputs conditioned.
- DB_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); minimum 2.
- HOLD_CYCLES, 50000000, cycles a press must be held before auto-repeat starts (used only with the macro).
- REPEAT_CYCLES, 20000000, cycles between auto-repeat pulses (used only with the macro).

Ports:
- clk  input  1  system clock; every register is clocked on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- btn_raw  input  N_BTN  raw, asynchronous, bouncing button/switch inputs.
- btn_level  output  N_BTN  debounced level per input, registered.
- btn_pulse  output  N_BTN  one-cycle pulse per input on each accepted 0->1 transition, registered.
- any_pulse  output  1  OR of btn_pulse, same cycle as btn_pulse; may be combinational from registered pulses.

Behaviour:
- Reset (rst=0, asynchronous): the following clear immediately and stay 0 while rst=0:
  - sync FFs, debounce counters, btn_level, btn_pulse, any_pulse;
  - auto-repeat counters, when present.
- Synchronizer: sync1 <= btn_raw, sync2 <= sync1. All later logic uses sync2 only.
- Debounce, per input i; counter width is $clog2(DB_CYCLES+1):
  - sync2[i] == btn_level[i]: counter cleared to 0.
  - sync2[i] != btn_level[i]: counter increments.
  - On the DB_CYCLES-th consecutive mismatching edge: btn_level[i] <= sync2[i] and counter <= 0.
  - Any single agreeing sample restarts the count from 0, so bounce shorter than DB_CYCLES is fully rejected.
- Latency: raw changes before edge 0 and stays stable. btn_level updates at edge 1+DB_CYCLES.
- One-shot:
  - btn_pulse[i] is asserted for exactly one cycle, at the same edge where btn_level[i] goes 0->1.
  - A 1->0 level change produces no pulse.
  - A held input produces no further pulses, unless the macro below is defined.
- Inputs are fully independent. Simultaneous accepted presses give simultaneous btn_pulse bits and a single-cycle any_pulse.
- Counter never wraps: it saturates conceptually at DB_CYCLES because the level update clears it.
- Reset released mid-count: all state restarts from 0. An input already high at reset release is accepted after 1+DB_CYCLES edges and pulses once.

Optional Feature:
- Macro: BTN_AUTOREPEAT_EN.
- Defined:
  - Per input, a hold counter runs while btn_level[i]=1.
  - First extra btn_pulse[i] comes HOLD_CYCLES edges after the initial pulse; further pulses follow every REPEAT_CYCLES edges while the input is still held.
  - btn_level[i] falling clears the hold counter; repeat state clears on reset.
  - Repeat pulses are also one cycle wide and are ORed into any_pulse.
- Not defined: no hold counters exist, HOLD_CYCLES and REPEAT_CYCLES are unused, and exactly one pulse is produced per press.

Test Plan:
Bench parameters: DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, N_BTN=4.
1. Reset: rst=0 with btn_raw=4'hF -> btn_level=0, btn_pulse=0, any_pulse=0 throughout. Raise rst with btn_raw held 4'hF -> btn_level=4'hF and btn_pulse=4'hF for one cycle, at edge 5 after release.
2. Clean press: btn_raw[0] 0->1 before edge 0, held -> btn_level[0]=1 and btn_pulse[0]=1 at edge 5. btn_pulse[0]=0 at edge 6 and after. any_pulse mirrors the pulse.
3. Bounce: btn_raw[1] toggles every 2 cycles for 12 cycles then stays 1 -> no pulse during bounce. One pulse at 5 edges after the last change.
4. Release and glitch:
   - btn_raw[0] 1->0 held -> btn_level[0] falls at edge 5, no pulse.
   - A 3-cycle high glitch on btn_raw[2] -> no level change, no pulse.
5. Simultaneous presses and mid-count reset:
   - btn_raw[3:2] rise together -> btn_pulse=4'b1100 for one cycle, any_pulse high for one cycle.
   - rst pulsed low at count 2 of a new press -> outputs 0 at once; pulse comes 5 edges after rst release.
6. With BTN_AUTOREPEAT_EN: hold btn_raw[0] for 30 cycles -> pulses at edges 5, 15, 18, 21, 24, ... while held. Without the macro -> only the edge-5 pulse.
